fu_mul_arbiter: RTL
===================

// Module: fu_mul_arbiter
// PURPOSE
//   Shares the single multi-cycle multiply unit (FU_mul-style: EN pulse, finish pulse, res) among
//   NREQ issue sources (reservation stations / issue slots) of the lab5 core.
//   Arbitrates round-robin, launches one operation at a time and tracks its destination tag.
//   Buffers the product with its tag until the writeback/CDB side accepts it.
//   Sits between the issue logic and the multiplier FU; the FU is non-pipelined, one op in flight.
// PARAMETERS
//   NREQ     4    number of requesters (2..8)
//   TAGW     4    destination tag width
//   WDOG     15   max cycles in WAIT before abort (watchdog, >= FU latency + 2)
// PORTS
//   clk         in   1          system clock, all state changes on posedge
//   rst_n       in   1          asynchronous active-low reset
//   req_valid   in   NREQ       request i pending; held until grant[i] seen
//   req_a       in   NREQ*32    operand A of requester i at bits [32*i+:32]
//   req_b       in   NREQ*32    operand B of requester i at bits [32*i+:32]
//   req_tag     in   NREQ*TAGW  destination tag of requester i at [TAGW*i+:TAGW]
//   grant       out  NREQ       one-hot, 1-cycle pulse: request i accepted
//   fu_en       out  1          launch pulse to multiplier (EN)
//   fu_a, fu_b  out  32         operands to multiplier, valid while fu_en=1
//   fu_finish   in   1          multiplier done pulse
//   fu_res      in   32         multiplier result, sampled when fu_finish=1
//   out_valid   out  1          result available
//   out_data    out  32         low 32 bits of product
//   out_tag     out  TAGW       tag of the op that produced out_data
//   out_ready   in   1          consumer accepts result when out_valid&out_ready
//   flush       in   1          squash: abandon in-flight op and buffered result
//   busy        out  1          1 in any state except IDLE
//   wdog_err    out  1          sticky: watchdog expired; cleared by reset only
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, rr_ptr=0; grant, fu_en, out_valid, busy, wdog_err = 0;
//     fu_a, fu_b, out_data = 0; out_tag = 0.
//   States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs registered.
//   IDLE: if any req_valid and !flush, pick winner = first set bit searching from rr_ptr upward
//     (wrapping at NREQ); latch its A/B/tag; next state ISSUE. No request: stay.
//   ISSUE (exactly 1 cycle): fu_en=1, grant[winner]=1, fu_a/fu_b = latched operands;
//     rr_ptr <= (winner+1) mod NREQ. Next state WAIT.
//   WAIT: fu_en=0; cycle counter counts from 1. On fu_finish=1: out_data<=fu_res, out_tag<=latched
//     tag, out_valid<=1, next DONE. Counter reaching WDOG without finish: wdog_err<=1, -> IDLE,
//     result discarded.
//   DONE: out_valid/out_data/out_tag held stable until out_valid&out_ready at an edge; then
//     out_valid<=0 and -> IDLE. No new grant in the acceptance cycle (min 1 IDLE cycle between ops).
//   Latency: req seen in IDLE at edge N -> grant/fu_en high in cycle N+1 -> out_valid at the edge
//     after fu_finish. With 7-stage FU finish, throughput is one op per >= 10 cycles.
//   flush (any state): at next edge -> IDLE, out_valid<=0, no grant issued; a fu_finish arriving
//     in or after the flush cycle is ignored. Flush during ISSUE: grant and fu_en still pulse in
//     that cycle (already registered); the op is launched, its result dropped. flush has priority
//     over req_valid and out_ready in the same cycle.
//   fu_finish outside WAIT is ignored. fu_en never asserts while state != ISSUE.
//   Requester must drop req_valid[i] the cycle after grant[i]; a still-asserted req is treated
//     as a new request.
// TESTING
//   1) Single op: req_valid=0001, A=7, B=6, tag=3 -> one grant=0001, fu_en pulse 1 cycle,
//      out_valid with out_data=42, out_tag=3; out_ready=1 -> out_valid=0 next cycle.
//   2) Round-robin: req_valid=1111 held/reissued -> grant order 0001,0010,0100,1000,0001.
//   3) Backpressure: out_ready=0 for 20 cycles in DONE -> out_data/out_tag stable, no new grant,
//      fu_en stays 0; out_ready=1 -> accepted, next grant after 1 IDLE cycle.
//   4) Flush in WAIT: launch 0xFFFF_FFFF*2, flush 2 cycles later -> busy=0 next cycle; FU finish
//      ignored, out_valid never rises; next request serviced normally.
//   5) Watchdog: FU model never asserts finish -> wdog_err=1 after WDOG cycles, state IDLE.
//   6) Async reset mid-WAIT: rst_n low between edges -> all outputs 0 immediately; later finish
//      ignored.

Source files
------------

// File: rtl/fu_mul_arbiter.sv
// Round-robin front end for one non-pipelined multiplier: grant/fu_en one cycle after a request is seen in IDLE,
// result one cycle after fu_finish, held in DONE until out_ready (no new grant until it is accepted).
module fu_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int TAGW = 4,
    parameter int WDOG = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [NREQ-1:0]      grant,
    output logic                 fu_en,
    output logic [31:0]          fu_a,
    output logic [31:0]          fu_b,
    input  logic                 fu_finish,
    input  logic [31:0]          fu_res,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    output logic [TAGW-1:0]      out_tag,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 busy,
    output logic                 wdog_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WDOG + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   rr_next;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            fu_en_q, fu_en_d;
    logic [31:0]     fu_a_q, fu_a_d;
    logic [31:0]     fu_b_q, fu_b_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_data_q, out_data_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;
    logic            busy_q, busy_d;
    logic            wdog_err_q, wdog_err_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [31:0]     pick_a;
    logic [31:0]     pick_b;
    logic [TAGW-1:0] pick_tag;
    int              j;

    assign rr_next = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);

    // First pending request at or above rr_ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_a   = '0;
        pick_b   = '0;
        pick_tag = '0;
        j        = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr_q) + k) % NREQ;
            if (!pick_vld && req_valid[j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
                pick_a   = req_a[32*j +: 32];
                pick_b   = req_b[32*j +: 32];
                pick_tag = req_tag[TAGW*j +: TAGW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        fu_en_d     = 1'b0;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        wdog_err_d  = wdog_err_q;

        if (flush) begin
            // An op squashed in ISSUE was still launched, so the pointer moves past it.
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            if (state_q == S_ISSUE) begin
                rr_ptr_d = rr_next;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        state_d           = S_ISSUE;
                        win_d             = pick_idx;
                        tag_d             = pick_tag;
                        fu_a_d            = pick_a;
                        fu_b_d            = pick_b;
                        grant_d[pick_idx] = 1'b1;
                        fu_en_d           = 1'b1;
                    end
                end
                S_ISSUE: begin
                    rr_ptr_d = rr_next;
                    cnt_d    = CW'(1);
                    state_d  = S_WAIT;
                end
                S_WAIT: begin
                    if (fu_finish) begin
                        out_valid_d = 1'b1;
                        out_data_d  = fu_res;
                        out_tag_d   = tag_q;
                        state_d     = S_DONE;
                    end else if (cnt_q == CW'(WDOG)) begin
                        wdog_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            fu_en_q     <= 1'b0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            busy_q      <= 1'b0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            fu_en_q     <= fu_en_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            busy_q      <= busy_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign grant     = grant_q;
    assign fu_en     = fu_en_q;
    assign fu_a      = fu_a_q;
    assign fu_b      = fu_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign busy      = busy_q;
    assign wdog_err  = wdog_err_q;
endmodule
